// File: rtl/oflow_best_match_selector.sv
// rtl/oflow_best_match_selector.sv - best/second-best score tracker with threshold and ambiguity decision
// Consumes one score per candidate, then registers the selected ID and decision flags with a done pulse.
module oflow_best_match_selector #(
  parameter int SCORE_LEN = 32,
  parameter int ID_LEN    = 12,
  parameter int CNT_LEN   = 8
) (
  input  logic                 clk,
  input  logic                 reset_N,
  input  logic                 start,
  input  logic [CNT_LEN-1:0]   num_candidates,
  input  logic                 score_valid,
  input  logic [SCORE_LEN-1:0] score,
  input  logic [ID_LEN-1:0]    score_id,
  input  logic [SCORE_LEN-1:0] threshold,
  input  logic [SCORE_LEN-1:0] margin,
  output logic                 busy,
  output logic                 done,
  output logic [ID_LEN-1:0]    best_id,
  output logic [SCORE_LEN-1:0] best_score,
  output logic [SCORE_LEN-1:0] second_score,
  output logic                 match_found,
  output logic                 ambiguous
);

  typedef enum logic [1:0] {IDLE, COLLECT, DECIDE} state_e;

  state_e                state_q, state_d;
  logic [CNT_LEN-1:0]    n_q, n_d;
  logic [CNT_LEN-1:0]    cnt_q, cnt_d;
  logic [CNT_LEN-1:0]    cnt_inc;
  logic [SCORE_LEN-1:0]  best_acc_q, best_acc_d;
  logic [SCORE_LEN-1:0]  second_acc_q, second_acc_d;
  logic [ID_LEN-1:0]     best_id_acc_q, best_id_acc_d;

  logic                  done_q;
  logic [ID_LEN-1:0]     best_id_q;
  logic [SCORE_LEN-1:0]  best_score_q;
  logic [SCORE_LEN-1:0]  second_score_q;
  logic                  match_q;
  logic                  amb_q;

  logic                  decide;
  logic                  match_d;
  logic                  amb_d;
  logic [SCORE_LEN-1:0]  gap;

  assign cnt_inc = cnt_q + {{(CNT_LEN-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_candidates == '0) ? DECIDE : COLLECT;
      COLLECT: if (score_valid && (cnt_inc == n_q)) state_d = DECIDE;
      DECIDE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // second_acc >= best_acc always holds, so the gap cannot underflow
  always_comb begin
    busy    = (state_q != IDLE);
    decide  = (state_q == DECIDE);
    gap     = second_acc_q - best_acc_q;
    match_d = (cnt_q != '0) && (best_acc_q <= threshold);
    amb_d   = match_d && (cnt_q > CNT_LEN'(1)) && (gap < margin);
  end

  always_comb begin
    n_d           = n_q;
    cnt_d         = cnt_q;
    best_acc_d    = best_acc_q;
    second_acc_d  = second_acc_q;
    best_id_acc_d = best_id_acc_q;
    if (state_q == IDLE && start) begin
      n_d           = num_candidates;
      cnt_d         = '0;
      best_acc_d    = '1;
      second_acc_d  = '1;
      best_id_acc_d = '0;
    end else if (state_q == COLLECT && score_valid) begin
      cnt_d = cnt_inc;
      // strict compares: on a tie the earlier arrival keeps best
      if (score < best_acc_q) begin
        second_acc_d  = best_acc_q;
        best_acc_d    = score;
        best_id_acc_d = score_id;
      end else if (score < second_acc_q) begin
        second_acc_d = score;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      n_q            <= '0;
      cnt_q          <= '0;
      best_acc_q     <= '1;
      second_acc_q   <= '1;
      best_id_acc_q  <= '0;
      done_q         <= 1'b0;
      best_id_q      <= '0;
      best_score_q   <= '0;
      second_score_q <= '0;
      match_q        <= 1'b0;
      amb_q          <= 1'b0;
    end else begin
      n_q           <= n_d;
      cnt_q         <= cnt_d;
      best_acc_q    <= best_acc_d;
      second_acc_q  <= second_acc_d;
      best_id_acc_q <= best_id_acc_d;
      done_q        <= decide;
      if (decide) begin
        best_id_q      <= best_id_acc_q;
        best_score_q   <= best_acc_q;
        second_score_q <= second_acc_q;
        match_q        <= match_d;
        amb_q          <= amb_d;
      end
    end
  end

  assign done         = done_q;
  assign best_id      = best_id_q;
  assign best_score   = best_score_q;
  assign second_score = second_score_q;
  assign match_found  = match_q;
  assign ambiguous    = amb_q;

endmodule

// File: tb/tb_oflow_best_match_selector.sv
// tb/tb_oflow_best_match_selector.sv - directed self-checking bench for oflow_best_match_selector
module tb_oflow_best_match_selector;

  localparam int SL = 32;
  localparam int IL = 12;
  localparam int CL = 8;
  localparam logic [SL-1:0] ONES = '1;

  logic          clk = 1'b0;
  logic          reset_N;
  logic          start;
  logic [CL-1:0] num_candidates;
  logic          score_valid;
  logic [SL-1:0] score;
  logic [IL-1:0] score_id;
  logic [SL-1:0] threshold;
  logic [SL-1:0] margin;
  logic          busy;
  logic          done;
  logic [IL-1:0] best_id;
  logic [SL-1:0] best_score;
  logic [SL-1:0] second_score;
  logic          match_found;
  logic          ambiguous;

  int total = 0;
  int bad   = 0;
  int lat;
  int done_seen;

  oflow_best_match_selector #(.SCORE_LEN(SL), .ID_LEN(IL), .CNT_LEN(CL)) dut (
    .clk(clk), .reset_N(reset_N), .start(start), .num_candidates(num_candidates),
    .score_valid(score_valid), .score(score), .score_id(score_id),
    .threshold(threshold), .margin(margin), .busy(busy), .done(done),
    .best_id(best_id), .best_score(best_score), .second_score(second_score),
    .match_found(match_found), .ambiguous(ambiguous)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_obj(input int n);
    @(posedge clk); #1;
    start = 1'b1; num_candidates = CL'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [SL-1:0] s, input logic [IL-1:0] id);
    score_valid = 1'b1; score = s; score_id = id;
    @(posedge clk); #1;
    score_valid = 1'b0;
  endtask

  // counts falling edges until done is seen; 0 means it never came
  task automatic wait_done(output int l);
    l = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic chk_result(input string tag, input logic [IL-1:0] id, input logic [SL-1:0] b,
                            input logic [SL-1:0] s2, input logic m, input logic a);
    chk({tag, ".lat"}, lat, 2);
    chk({tag, ".best_id"}, best_id, id);
    chk({tag, ".best"}, best_score, b);
    chk({tag, ".second"}, second_score, s2);
    chk({tag, ".match"}, match_found, m);
    chk({tag, ".amb"}, ambiguous, a);
  endtask

  initial begin
    reset_N = 1'b0; start = 1'b0; num_candidates = '0; score_valid = 1'b0;
    score = '0; score_id = '0; threshold = 32'h1000; margin = 32'h40;
    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.best_id", best_id, 0);
    chk("rst.best", best_score, 0);
    chk("rst.second", second_score, 0);
    chk("rst.match", match_found, 0);
    chk("rst.amb", ambiguous, 0);
    reset_N = 1'b1;

    start_obj(3);
    @(negedge clk); chk("basic.busy", busy, 1);
    @(posedge clk); #1;
    send(32'h800, 5); send(32'h300, 9); send(32'h500, 2);
    wait_done(lat);
    chk_result("basic", 9, 32'h300, 32'h500, 1, 0);
    @(negedge clk);
    chk("basic.pulse", done, 0);
    chk("basic.hold", best_id, 9);
    chk("basic.idle", busy, 0);

    margin = 32'h1;
    start_obj(2);
    send(32'h200, 7); send(32'h200, 3);
    wait_done(lat);
    chk_result("tie", 7, 32'h200, 32'h200, 1, 1);

    threshold = 32'h100;
    start_obj(2);
    send(32'h400, 1); send(32'h150, 2);
    wait_done(lat);
    chk_result("thr", 2, 32'h150, 32'h400, 0, 0);

    threshold = 32'h1000;
    start_obj(0);
    wait_done(lat);
    chk_result("empty", 0, ONES, ONES, 0, 0);

    start_obj(1);
    send(32'h10, 4);
    wait_done(lat);
    chk_result("single", 4, 32'h10, ONES, 1, 0);

    // stray start mid-collect plus gaps between valids
    start_obj(3);
    send(32'h50, 1);
    start = 1'b1; num_candidates = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); chk("midstart.busy", busy, 1);
    @(posedge clk); #1;
    send(32'h40, 2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    send(32'h60, 3);
    wait_done(lat);
    chk_result("midstart", 2, 32'h40, 32'h50, 1, 0);

    // start during the done cycle is accepted
    start = 1'b1; num_candidates = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); chk("b2b.busy", busy, 1);
    @(posedge clk); #1;
    send(32'h20, 11);
    wait_done(lat);
    chk_result("b2b", 11, 32'h20, ONES, 1, 0);

    // async reset after 1 of 3 scores
    start_obj(3);
    send(32'h70, 8);
    @(negedge clk);
    reset_N = 1'b0;
    #1;
    chk("rmid.busy", busy, 0);
    chk("rmid.best_id", best_id, 0);
    chk("rmid.best", best_score, 0);
    chk("rmid.match", match_found, 0);
    done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    reset_N = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("rmid.nodone", done_seen, 0);
    chk("rmid.idle", busy, 0);
    @(posedge clk); #1;
    send(32'h5, 15);
    start_obj(1);
    send(32'h30, 6);
    wait_done(lat);
    chk_result("post_rst", 6, 32'h30, ONES, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
